// File: rtl/apb_master.sv
// rtl/apb_master.sv - APB requester bridge: valid/ready command in, APB SETUP/ACCESS out, one-cycle response pulse
//
// Ports:
//   PCLK, PRESET                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready               command handshake (accepted when both high)
//   cmd_write, cmd_addr, cmd_wdata    command direction, address, write data
//   rsp_valid, rsp_rdata, rsp_err     one-cycle completion pulse, read data (0 on writes), error
//   PSEL, PENABLE, PWRITE, PADDR,
//   PWDATA, PRDATA, PREADY, PSLVERR   APB requester bus
//
// Optional feature: define APB_MASTER_TIMEOUT_EN to abort an ACCESS phase once
// PREADY has stayed low for TIMEOUT cycles (response carries rsp_err=1, rdata=0).
module apb_master #(
    parameter int AWIDTH  = 8,
    parameter int DWIDTH  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [DWIDTH-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [AWIDTH-1:0] PADDR,
    output logic [DWIDTH-1:0] PWDATA,
    input  logic [DWIDTH-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              pwrite_q, pwrite_d;
    logic [AWIDTH-1:0] paddr_q, paddr_d;
    logic [DWIDTH-1:0] pwdata_q, pwdata_d;
    logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
`else
    // TIMEOUT only matters when the ACCESS watchdog is built in.
    localparam int TIMEOUT_UNUSED = TIMEOUT;
`endif

    always_comb begin
        state_d     = state_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
`ifdef APB_MASTER_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                // Ready takes priority over an expiring watchdog on the same cycle.
                if (PREADY) begin
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                    rsp_err_d   = PSLVERR;
                    state_d     = S_RESP;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                else if (tmo_cnt_q == CW'(TIMEOUT)) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= S_IDLE;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

    // Bus phase and handshake signals are pure decodes of the state register.
    assign cmd_ready = (state_q == S_IDLE);
    assign PSEL      = (state_q == S_SETUP) || (state_q == S_ACCESS);
    assign PENABLE   = (state_q == S_ACCESS);
    assign rsp_valid = (state_q == S_RESP);
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - scoreboard bench for apb_master with a randomized APB slave model
module tb_apb_master;

    localparam int TIMEOUT = 16;
    localparam int HANG    = 1000;

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [7:0] cmd_addr, cmd_wdata;
    logic       rsp_valid, rsp_err;
    logic [7:0] rsp_rdata;
    logic       PSEL, PENABLE, PWRITE;
    logic [7:0] PADDR, PWDATA, PRDATA;
    logic       PREADY, PSLVERR;

    apb_master #(.AWIDTH(8), .DWIDTH(8), .TIMEOUT(TIMEOUT)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        bit       wr;
        bit [7:0] addr;
        bit [7:0] wdata;
        bit [7:0] prdata;
        bit       err;
        int       waits;
    } slv_t;

    typedef struct {
        bit [7:0] rdata;
        bit       err;
        int       cyc;
    } exp_t;

    slv_t slv_q[$];
    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   last_issue = 0;
    int   acc_cnt = 0;
    bit   prev_psel = 0;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // APB slave model: answers the oldest issued transfer after its wait count,
    // and drives junk on PRDATA/PREADY/PSLVERR whenever the value must be ignored.
    always @(negedge PCLK) begin
        if (PSEL === 1'b1 && slv_q.size() > 0) begin
            chk("paddr", PADDR, slv_q[0].addr);
            chk("pwrite", PWRITE, slv_q[0].wr);
            chk("pwdata", PWDATA, slv_q[0].wdata);
            chk("penable_phase", PENABLE, prev_psel);
        end
        prev_psel = (PSEL === 1'b1);
        if (PSEL === 1'b1 && PENABLE === 1'b1) begin
            if (slv_q.size() > 0 && acc_cnt == slv_q[0].waits) begin
                PREADY  = 1'b1;
                PRDATA  = slv_q[0].prdata;
                PSLVERR = slv_q[0].err;
                void'(slv_q.pop_front());
                acc_cnt = 0;
            end else begin
                PREADY  = 1'b0;
                PRDATA  = 8'($urandom);
                PSLVERR = 1'($urandom);
                acc_cnt++;
            end
        end else begin
            PREADY  = 1'($urandom);
            PRDATA  = 8'($urandom);
            PSLVERR = 1'($urandom);
            acc_cnt = 0;
        end
    end

    // Response monitor: every pulse must match the oldest expectation, on time.
    always @(negedge PCLK) begin
        if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", rsp_err, e.err);
                chk("rsp_cycle", cyc, e.cyc);
                chk("psel_in_resp", PSEL, 0);
                chk("ready_in_resp", cmd_ready, 0);
            end
        end
    end

    // Reference model: what a transfer should return and when, from the bus rules.
    task automatic issue(input bit wr, input bit [7:0] addr, input bit [7:0] wdata,
                         input int waits, input bit [7:0] prdata, input bit err);
        int   n = 0;
        slv_t s;
        exp_t e;
        while (cmd_ready !== 1'b1 && n < 300) begin
            @(negedge PCLK);
            n++;
        end
        if (cmd_ready !== 1'b1) begin
            chk("cmd_ready_wait", cmd_ready, 1);
            return;
        end
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        last_issue = cyc;
        s = '{wr, addr, wdata, prdata, err, waits};
        slv_q.push_back(s);
`ifdef APB_MASTER_TIMEOUT_EN
        if (waits > TIMEOUT) begin
            e = '{8'h00, 1'b1, cyc + 3 + TIMEOUT};
            exp_q.push_back(e);
        end else
`endif
        if (waits < HANG) begin
            e = '{(wr ? 8'h00 : prdata), err, cyc + 3 + waits};
            exp_q.push_back(e);
        end
        @(negedge PCLK);
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = 8'($urandom);
        cmd_wdata = 8'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            @(negedge PCLK);
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        PRESET = 1'b1;
        @(negedge PCLK);
        exp_q.delete();
        slv_q.delete();
        PRESET = 1'b0;
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_paddr", PADDR, 0);
    endtask

    initial begin
        int t0;
        PRESET    = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'hFF;
        cmd_wdata = 8'hFF;
        PREADY    = 1'b0;
        PRDATA    = 8'h00;
        PSLVERR   = 1'b0;

        // Reset held 3 cycles with a command offered: it must be ignored.
        repeat (3) begin
            @(negedge PCLK);
            chk("rst_hold_psel", PSEL, 0);
            chk("rst_hold_rsp_valid", rsp_valid, 0);
        end
        PRESET    = 1'b0;
        cmd_valid = 1'b0;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_penable", PENABLE, 0);
        chk("rst_pwrite", PWRITE, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        @(negedge PCLK);
        chk("no_accept_after_rst", PSEL, 0);

        // Directed: zero-wait write, back-to-back waited read, error then clean write.
        issue(1'b1, 8'h12, 8'hA5, 0, 8'h77, 1'b0);
        t0 = last_issue;
        issue(1'b0, 8'h34, 8'h00, 3, 8'h3C, 1'b0);
        chk("accept_to_accept", last_issue - t0, 4);
        issue(1'b0, 8'h56, 8'h11, 1, 8'h99, 1'b1);
        issue(1'b1, 8'h78, 8'h22, 0, 8'h55, 1'b0);
        drain();

        // Randomized traffic with random idle gaps.
        for (int i = 0; i < 40; i++) begin
            issue(1'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 4),
                  8'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge PCLK);
        end
        drain();

        // Reset in the middle of an ACCESS phase: no response, bus idles.
        issue(1'b0, 8'h9A, 8'h00, HANG, 8'h00, 1'b0);
        repeat (3) @(negedge PCLK);
        chk("mid_access_penable", PENABLE, 1);
        do_reset();
        repeat (2) @(negedge PCLK);
        issue(1'b0, 8'hBC, 8'h00, 2, 8'hE7, 1'b0);
        drain();

`ifdef APB_MASTER_TIMEOUT_EN
        // Slave never ready: watchdog aborts with an error.
        issue(1'b0, 8'hC3, 8'h00, HANG, 8'hAA, 1'b0);
        drain();
        slv_q.delete();
        // Ready arriving exactly as the watchdog expires completes normally.
        issue(1'b0, 8'hC4, 8'h00, TIMEOUT, 8'h5A, 1'b0);
        drain();
`else
        // Without the watchdog the bridge waits in ACCESS indefinitely.
        issue(1'b0, 8'hC3, 8'h00, HANG, 8'hAA, 1'b0);
        repeat (100) @(negedge PCLK);
        chk("hang_psel", PSEL, 1);
        chk("hang_penable", PENABLE, 1);
        do_reset();
`endif
        issue(1'b1, 8'hD5, 8'h6B, 0, 8'h00, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
